adc_sequencer: RTL

Scan controller for the 10-bit serial ADC front end. Walks a mask of enabled analog channels, issues one conversion request per channel to the ADC conversion core over a start/done handshake, and stores the latest result for each channel in a register bank. Other logic (CPU peripheral bus, LED/servo demos) reads the bank at any time without touching the ADC timing. Sits between the ADC core and the peripheral bus.

---
 rtl/adc_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/adc_sequencer.sv
// Scan controller: walks an enabled-channel mask, runs one ADC conversion per channel and keeps
// the latest result per channel in a readable bank. ADC_SEQ_AVG_EN selects 4-sample averaging.
module adc_sequencer #(
  parameter int          NUM_CH      = 8,
  parameter int          SAMPLE_BITS = 10,
  parameter logic [15:0] INTERVAL    = 16'd1000,
  parameter logic [15:0] TIMEOUT     = 16'd8192,
  localparam int         CW          = $clog2(NUM_CH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   run,
  input  logic [NUM_CH-1:0]      chan_mask,
  output logic                   conv_start,
  output logic [CW-1:0]          conv_chan,
  input  logic                   conv_done,
  input  logic [SAMPLE_BITS-1:0] conv_data,
  input  logic [CW-1:0]          rd_chan,
  output logic [SAMPLE_BITS-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   scan_done,
  output logic                   err,
  input  logic                   clear_err
);

  // state  | meaning
  // IDLE   | waiting for run
  // WAIT   | interval between scans
  // SELECT | find lowest pending channel
  // ISSUE  | request a conversion
  // BUSY   | waiting for conv_done or timeout
  // STORE  | write result to the bank
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_BUSY   = 3'd4;
  localparam logic [2:0] S_STORE  = 3'd5;

`ifdef ADC_SEQ_AVG_EN
  localparam int ACW = SAMPLE_BITS + 2;
  logic [1:0] avg_cnt;
`else
  localparam int ACW = SAMPLE_BITS;
`endif

  logic [2:0]             state;
  logic [NUM_CH-1:0]      snap;
  logic [CW-1:0]          ptr;
  logic [15:0]            cnt;
  logic [ACW-1:0]         acc;
  logic [SAMPLE_BITS-1:0] bank [NUM_CH];
  logic [NUM_CH-1:0]      valid;
  logic                   found;
  logic [CW-1:0]          next_ch;
  logic [SAMPLE_BITS-1:0] store_val;

  // Serviced channels are cleared from the snapshot, so the lowest set bit is at or above ptr.
  always_comb begin
    found   = 1'b0;
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap[i]) begin
        found   = 1'b1;
        next_ch = CW'(i);
      end
    end
  end

`ifdef ADC_SEQ_AVG_EN
  assign store_val = acc[ACW-1:2];
`else
  assign store_val = acc;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      snap       <= '0;
      ptr        <= '0;
      cnt        <= '0;
      acc        <= '0;
      valid      <= '0;
      conv_start <= 1'b0;
      conv_chan  <= '0;
      scan_done  <= 1'b0;
      err        <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
`ifdef ADC_SEQ_AVG_EN
      avg_cnt    <= '0;
`endif
    end else begin
      conv_start <= 1'b0;
      scan_done  <= 1'b0;
      rd_data    <= bank[rd_chan];
      rd_valid   <= valid[rd_chan];
      if (clear_err) err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (run) begin
            snap  <= chan_mask;
            ptr   <= '0;
            state <= S_SELECT;
          end
        end
        S_WAIT: begin
          if (!run) begin
            state <= S_IDLE;
          end else if (cnt == 16'd0) begin
            snap  <= chan_mask;
            ptr   <= '0;
            state <= S_SELECT;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_SELECT: begin
          if (found && run) begin
            ptr   <= next_ch;
            state <= S_ISSUE;
          end else begin
            scan_done <= 1'b1;
            if (run) begin
              cnt   <= INTERVAL;
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_ISSUE: begin
          conv_start <= 1'b1;
          conv_chan  <= ptr;
          cnt        <= TIMEOUT - 16'd1;
          state      <= S_BUSY;
        end
        S_BUSY: begin
          if (conv_done) begin
`ifdef ADC_SEQ_AVG_EN
            acc <= acc + ACW'(conv_data);
            if (avg_cnt == 2'd3) begin
              state <= S_STORE;
            end else begin
              avg_cnt <= avg_cnt + 2'd1;
              state   <= S_ISSUE;
            end
`else
            acc   <= conv_data;
            state <= S_STORE;
`endif
          end else if (cnt == 16'd0) begin
            err        <= 1'b1;
            snap[ptr]  <= 1'b0;
            acc        <= '0;
`ifdef ADC_SEQ_AVG_EN
            avg_cnt    <= '0;
`endif
            state      <= S_SELECT;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STORE: begin
          bank[ptr]  <= store_val;
          valid[ptr] <= 1'b1;
          snap[ptr]  <= 1'b0;
          acc        <= '0;
`ifdef ADC_SEQ_AVG_EN
          avg_cnt    <= '0;
`endif
          state      <= S_SELECT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
